// File: rtl/decode_out_pkg_hdl.sv
// Shared decode definitions for the decode stage.
// Holds the opcodes, control field encodings and writeback selects.
package decode_out_pkg_hdl;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RES  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;

  localparam logic [1:0] PC1_NONE = 2'b00;
  localparam logic [1:0] PC1_OFF9 = 2'b01;
  localparam logic [1:0] PC1_OFF6 = 2'b10;
  localparam logic [1:0] PC1_BASE = 2'b11;

  localparam logic [1:0] W_ALU    = 2'd0;
  localparam logic [1:0] W_MEM    = 2'd1;
  localparam logic [1:0] W_PCREL  = 2'd2;

  typedef struct packed {
    logic [1:0] alu;
    logic [1:0] pcsel1;
    logic       pcsel2;
    logic       op2sel;
  } e_ctrl_t;

endpackage

// File: rtl/decode_ctrl_lut.sv
// Combinational opcode to control-bundle decoder.
// Unsupported opcodes return zero controls with illegal_o set.
module decode_ctrl_lut
  import decode_out_pkg_hdl::*;
(
  input  logic [3:0] op_i,
  input  logic       imm_i,
  output logic [5:0] e_ctrl_o,
  output logic [1:0] w_ctrl_o,
  output logic       mem_ctrl_o,
  output logic       illegal_o
);

  opcode_e op;
  e_ctrl_t e;

  assign op       = opcode_e'(op_i);
  assign e_ctrl_o = e;

  always_comb begin
    e          = '0;
    w_ctrl_o   = W_ALU;
    mem_ctrl_o = 1'b0;
    illegal_o  = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        e.alu    = ALU_ADD;
        e.op2sel = ~imm_i;
      end
      (op == OP_AND): begin
        e.alu    = ALU_AND;
        e.op2sel = ~imm_i;
      end
      (op == OP_NOT): begin
        e.alu    = ALU_NOT;
        e.op2sel = 1'b1;
      end
      (op == OP_BR || op == OP_ST): begin
        e.pcsel1 = PC1_OFF9;
        e.pcsel2 = 1'b1;
      end
      (op == OP_LD): begin
        e.pcsel1 = PC1_OFF9;
        e.pcsel2 = 1'b1;
        w_ctrl_o = W_MEM;
      end
      (op == OP_LDI): begin
        e.pcsel1   = PC1_OFF9;
        e.pcsel2   = 1'b1;
        w_ctrl_o   = W_MEM;
        mem_ctrl_o = 1'b1;
      end
      (op == OP_STI): begin
        e.pcsel1   = PC1_OFF9;
        e.pcsel2   = 1'b1;
        mem_ctrl_o = 1'b1;
      end
      (op == OP_LEA): begin
        e.pcsel1 = PC1_OFF9;
        e.pcsel2 = 1'b1;
        w_ctrl_o = W_PCREL;
      end
      (op == OP_LDR): begin
        e.pcsel1 = PC1_OFF6;
        w_ctrl_o = W_MEM;
      end
      (op == OP_STR): e.pcsel1 = PC1_OFF6;
      (op == OP_JMP): e.pcsel1 = PC1_BASE;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: captures the fetched word and its
// decoded controls, and counts accepted instructions.
module decode_stage
  import decode_out_pkg_hdl::*;
#(
  parameter int COUNT_W       = 16,
  parameter int ILLEGAL_CLEAR = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_decode,
  input  logic [15:0]        dout,
  input  logic [15:0]        npc_in,
  output logic [15:0]        IR,
  output logic [15:0]        npc_out,
  output logic [5:0]         E_Control,
  output logic [1:0]         W_Control,
  output logic               Mem_Control,
  output logic               decode_valid,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] decode_count
);

  logic [5:0]         lut_e;
  logic [1:0]         lut_w;
  logic               lut_mem;
  logic               lut_ill;

  logic [15:0]        ir_q, npc_q;
  logic [5:0]         e_q, e_d;
  logic [1:0]         w_q, w_d;
  logic               mem_q, mem_d;
  logic               vld_q, ill_q;
  logic [COUNT_W-1:0] cnt_q;

  decode_ctrl_lut u_lut (
    .op_i       (dout[15:12]),
    .imm_i      (dout[5]),
    .e_ctrl_o   (lut_e),
    .w_ctrl_o   (lut_w),
    .mem_ctrl_o (lut_mem),
    .illegal_o  (lut_ill)
  );

  // Without clearing, an illegal opcode leaves the prior controls.
  always_comb begin
    e_d   = lut_e;
    w_d   = lut_w;
    mem_d = lut_mem;
    if (lut_ill && ILLEGAL_CLEAR == 0) begin
      e_d   = e_q;
      w_d   = w_q;
      mem_d = mem_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q  <= '0;
      npc_q <= '0;
      e_q   <= '0;
      w_q   <= '0;
      mem_q <= 1'b0;
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= enable_decode;
      if (enable_decode) begin
        ir_q  <= dout;
        npc_q <= npc_in;
        e_q   <= e_d;
        w_q   <= w_d;
        mem_q <= mem_d;
        ill_q <= lut_ill;
        cnt_q <= cnt_q + COUNT_W'(1);
      end
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = e_q;
  assign W_Control    = w_q;
  assign Mem_Control  = mem_q;
  assign decode_valid = vld_q;
  assign illegal_op   = ill_q;
  assign decode_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage, with a second
// narrow-counter instance to exercise wraparound.
module tb_decode_stage;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout, npc_in;
  logic [15:0] IR, npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control, decode_valid, illegal_op;
  logic [15:0] decode_count;

  logic [15:0] ir4, npc4;
  logic [5:0]  e4;
  logic [1:0]  w4;
  logic        m4, v4, i4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  exp_t last;
  logic [15:0] mcnt = '0;

  always #5 clock = ~clock;

  decode_stage dut (
    .clock(clock), .reset(reset),
    .enable_decode(enable_decode),
    .dout(dout), .npc_in(npc_in),
    .IR(IR), .npc_out(npc_out),
    .E_Control(E_Control), .W_Control(W_Control),
    .Mem_Control(Mem_Control),
    .decode_valid(decode_valid),
    .illegal_op(illegal_op),
    .decode_count(decode_count)
  );

  decode_stage #(.COUNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .enable_decode(enable_decode),
    .dout(dout), .npc_in(npc_in),
    .IR(ir4), .npc_out(npc4),
    .E_Control(e4), .W_Control(w4),
    .Mem_Control(m4),
    .decode_valid(v4),
    .illegal_op(i4),
    .decode_count(cnt4)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [15:0] ins, logic [15:0] npc);
    exp_t x;
    logic n5;
    n5 = ~ins[5];
    x.ir = ins; x.npc = npc;
    x.e = 6'b0; x.w = 2'd0; x.m = 1'b0; x.ill = 1'b0;
    case (ins[15:12])
      4'h1: x.e = {2'b00, 2'b00, 1'b0, n5};
      4'h5: x.e = {2'b01, 2'b00, 1'b0, n5};
      4'h9: x.e = 6'b100001;
      4'h0, 4'h3: x.e = 6'b000110;
      4'h2: begin x.e = 6'b000110; x.w = 2'd1; end
      4'hA: begin x.e = 6'b000110; x.w = 2'd1; x.m = 1'b1; end
      4'hB: begin x.e = 6'b000110; x.m = 1'b1; end
      4'hE: begin x.e = 6'b000110; x.w = 2'd2; end
      4'h6: begin x.e = 6'b001000; x.w = 2'd1; end
      4'h7: x.e = 6'b001000;
      4'hC: x.e = 6'b001100;
      default: x.ill = 1'b1;
    endcase
    x.cnt = 16'(mcnt + 16'd1);
    return x;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out();
    exp_t x;
    if (decode_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(decode_valid), 32'd0);
      end else begin
        x = sb.pop_front();
        chk("ir", 32'(IR), 32'(x.ir));
        chk("npc", 32'(npc_out), 32'(x.npc));
        chk("e", 32'(E_Control), 32'(x.e));
        chk("w", 32'(W_Control), 32'(x.w));
        chk("mem", 32'(Mem_Control), 32'(x.m));
        chk("ill", 32'(illegal_op), 32'(x.ill));
        chk("cnt", 32'(decode_count), 32'(x.cnt));
        chk("cnt4", 32'(cnt4), 32'(x.cnt[3:0]));
      end
    end else if (sb.size() != 0) begin
      chk("missing_valid", 32'(decode_valid), 32'd1);
      sb.delete();
    end
  endtask

  task automatic issue(logic [15:0] ins, logic [15:0] npc);
    exp_t x;
    enable_decode = 1'b1;
    dout = ins;
    npc_in = npc;
    x = model(ins, npc);
    mcnt = x.cnt;
    last = x;
    sb.push_back(x);
    tick();
    check_out();
  endtask

  task automatic idle_hold(string tag);
    enable_decode = 1'b0;
    dout = 16'($urandom);
    npc_in = 16'($urandom);
    tick();
    check_out();
    chk({tag, "_dv"}, 32'(decode_valid), 32'd0);
    chk({tag, "_ir"}, 32'(IR), 32'(last.ir));
    chk({tag, "_npc"}, 32'(npc_out), 32'(last.npc));
    chk({tag, "_e"}, 32'(E_Control), 32'(last.e));
    chk({tag, "_w"}, 32'(W_Control), 32'(last.w));
    chk({tag, "_cnt"}, 32'(decode_count), 32'(mcnt));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ir"}, 32'(IR), 32'd0);
    chk({tag, "_npc"}, 32'(npc_out), 32'd0);
    chk({tag, "_e"}, 32'(E_Control), 32'd0);
    chk({tag, "_w"}, 32'(W_Control), 32'd0);
    chk({tag, "_mem"}, 32'(Mem_Control), 32'd0);
    chk({tag, "_dv"}, 32'(decode_valid), 32'd0);
    chk({tag, "_ill"}, 32'(illegal_op), 32'd0);
    chk({tag, "_cnt"}, 32'(decode_count), 32'd0);
    chk({tag, "_cnt4"}, 32'(cnt4), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    enable_decode = 1'b0;
    dout = '0;
    npc_in = '0;
    repeat (3) tick();
    chk_zero("rst");
    reset = 1'b0;
    mcnt = '0;

    issue(16'h1261, 16'h3001);
    issue(16'hA402, 16'h3002);
    issue(16'h7181, 16'h3003);
    issue(16'hE7FF, 16'h3004);
    idle_hold("hold");

    issue(16'hF025, 16'h3005);
    chk("trap_ill", 32'(illegal_op), 32'd1);
    issue(16'h1042, 16'h3006);
    chk("trap_clr", 32'(illegal_op), 32'd0);

    // every opcode, with both immediate-bit values
    for (int i = 0; i < 32; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[15:12] = 4'(i >> 1);
      w[5] = i[0];
      issue(w, 16'($urandom));
    end
    idle_hold("hold2");

    reset = 1'b1;
    enable_decode = 1'b1;
    dout = 16'h5123;
    npc_in = 16'h4444;
    tick();
    chk_zero("rst_en");
    reset = 1'b0;
    mcnt = '0;

    for (int i = 0; i < 17; i++)
      issue(16'($urandom), 16'($urandom));
    chk("wrap4", 32'(cnt4), 32'd1);
    chk("cnt17", 32'(decode_count), 32'd17);
    idle_hold("hold3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
